// File: rtl/det3_sequencer.sv
// det3_sequencer: computes the determinant of a signed 3x3 matrix held in an
// external synchronous memory. The Sarrus expansion has six three-element
// product terms. Each element read takes one ADDR and one DATA cycle, and each
// term ends with one ACC cycle. One computation is therefore 6*7 = 42 cycles,
// followed by a single DONE cycle.
module det3_sequencer #(
    parameter int ELEM_W = 8,
    parameter int RES_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    output logic [3:0]               mem_addr_o,
    output logic                     mem_rd_o,
    input  logic signed [ELEM_W-1:0] mem_rdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic signed [RES_W-1:0]  result_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q;
    logic [2:0]              t_q;
    logic [1:0]              k_q;
    logic signed [RES_W-1:0] acc_q;
    logic signed [RES_W-1:0] prod_q;
    logic signed [RES_W-1:0] result_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    mem_rd_q;
    logic [3:0]              mem_addr_q;

    logic                    start_evt;
    logic signed [RES_W-1:0] rdata_ext;
    logic signed [RES_W-1:0] prod_d;
    logic signed [RES_W-1:0] acc_d;

    // Sarrus term table: element address for term t, factor k.
    // Terms 0..2 are added and terms 3..5 are subtracted.
    function automatic logic [3:0] tab_addr(input logic [2:0] t, input logic [1:0] k);
        logic [3:0] a;
        case ({t, k})
            5'b000_00: a = 4'd0;
            5'b000_01: a = 4'd4;
            5'b000_10: a = 4'd8;
            5'b001_00: a = 4'd1;
            5'b001_01: a = 4'd5;
            5'b001_10: a = 4'd6;
            5'b010_00: a = 4'd2;
            5'b010_01: a = 4'd3;
            5'b010_10: a = 4'd7;
            5'b011_00: a = 4'd2;
            5'b011_01: a = 4'd4;
            5'b011_10: a = 4'd6;
            5'b100_00: a = 4'd0;
            5'b100_01: a = 4'd5;
            5'b100_10: a = 4'd7;
            5'b101_00: a = 4'd1;
            5'b101_01: a = 4'd3;
            5'b101_10: a = 4'd8;
            default:   a = 4'd0;
        endcase
        return a;
    endfunction

    // A rising edge of start relative to the previous registered sample.
    assign start_evt = start_i & ~start_q;
    assign rdata_ext = {{(RES_W-ELEM_W){mem_rdata_i[ELEM_W-1]}}, mem_rdata_i};

    // Next product and accumulator values; each is consumed only in its own state.
    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        if (k_q == 2'd0) begin
            prod_d = rdata_ext;
        end else begin
            prod_d = prod_q * rdata_ext;
        end
        if (t_q < 3'd3) begin
            acc_d = acc_q + prod_q;
        end else begin
            acc_d = acc_q - prod_q;
        end
    end

    // Sequencer FSM with registered memory strobe, busy, done and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            t_q        <= 3'd0;
            k_q        <= 2'd0;
            acc_q      <= '0;
            prod_q     <= '0;
            result_q   <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 4'd0;
        end else begin
            start_q    <= start_i;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 4'd0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_evt) begin
                        state_q    <= S_ADDR;
                        t_q        <= 3'd0;
                        k_q        <= 2'd0;
                        acc_q      <= '0;
                        busy_q     <= 1'b1;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= tab_addr(3'd0, 2'd0);
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_ADDR: begin
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    prod_q <= prod_d;
                    if (k_q < 2'd2) begin
                        state_q    <= S_ADDR;
                        k_q        <= k_q + 2'd1;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= tab_addr(t_q, k_q + 2'd1);
                    end else begin
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc_q <= acc_d;
                    if (t_q < 3'd5) begin
                        state_q    <= S_ADDR;
                        t_q        <= t_q + 3'd1;
                        k_q        <= 2'd0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= tab_addr(t_q + 3'd1, 2'd0);
                    end else begin
                        // Final term: publish the result on entry to DONE.
                        state_q  <= S_DONE;
                        result_q <= acc_d;
                        done_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;

endmodule

// File: tb/tb_det3_sequencer.sv
// Scoreboard bench for det3_sequencer: stimulus pushes the expected result,
// completion cycle and read-address trace; the monitor checks them on the
// falling clock edge.
module tb_det3_sequencer;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic [3:0]         mem_addr_o;
    logic               mem_rd_o;
    logic signed [7:0]  mem_rdata_i;
    logic               busy_o;
    logic               done_o;
    logic signed [31:0] result_o;

    det3_sequencer #(.ELEM_W(8), .RES_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .mem_addr_o  (mem_addr_o),
        .mem_rd_o    (mem_rd_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   rd_cnt = 0;
    int   tab [18] = '{0,4,8, 1,5,6, 2,3,7, 2,4,6, 0,5,7, 1,3,8};
    logic signed [7:0] mat [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory model: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata_i <= mat[mem_addr_o];
    end

    // Monitor: compares each read address, each done pulse and idle address outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_o) begin
                rd_cnt = rd_cnt + 1;
                checks = checks + 1;
                if (addr_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL addr_unexpected got=%0d at cyc %0d", mem_addr_o, cyc);
                end else begin
                    int ea;
                    ea = addr_q.pop_front();
                    if (int'(mem_addr_o) != ea) begin
                        errors = errors + 1;
                        $display("FAIL addr_order got=%0d exp=%0d", mem_addr_o, ea);
                    end
                end
            end else begin
                checks = checks + 1;
                if (mem_addr_o !== 4'd0) begin
                    errors = errors + 1;
                    $display("FAIL addr_idle got=%0d exp=0", mem_addr_o);
                end
            end
            if (done_o) begin
                done_cnt = done_cnt + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL done_unexpected result=%0d at cyc %0d", result_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (result_o !== e.res) begin
                        errors = errors + 1;
                        $display("FAIL result got=%0d exp=%0d", result_o, e.res);
                    end
                    checks = checks + 1;
                    if (cyc != e.cyc) begin
                        errors = errors + 1;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.cyc);
                    end
                    checks = checks + 1;
                    if (rd_cnt != 18) begin
                        errors = errors + 1;
                        $display("FAIL rd_count got=%0d exp=18", rd_cnt);
                    end
                end
                rd_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_mat(input int m [9]);
        for (int i = 0; i < 16; i++) mat[i] = (i < 9) ? 8'(m[i]) : 8'sd0;
    endtask

    // Records the expected completion for an event sampled at edge e0.
    task automatic expect_run(input int e0, input int det);
        exp_t e;
        e.res = det;
        e.cyc = e0 + 42;
        exp_q.push_back(e);
        for (int i = 0; i < 18; i++) addr_q.push_back(tab[i]);
    endtask

    // Raises start at a falling edge; the next rising edge is E0.
    task automatic kick(input int det, output int e0);
        @(negedge clk);
        start_i = 1'b1;
        e0 = cyc + 1;
        expect_run(e0, det);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    int e0;

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        set_mat('{1,0,0, 0,1,0, 0,0,1});
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_rd", int'(mem_rd_o), 0);
        check("rst_addr", int'(mem_addr_o), 0);
        check("rst_result", int'(result_o), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Identity matrix.
        kick(1, e0);
        @(negedge clk);
        start_i = 1'b0;
        wait_until(e0 + 44);

        // Near-singular matrix, all-ones matrix, negative diagonal.
        set_mat('{1,2,3, 4,5,6, 7,8,10});
        kick(-3, e0);
        @(negedge clk);
        start_i = 1'b0;
        wait_until(e0 + 44);
        set_mat('{1,1,1, 1,1,1, 1,1,1});
        kick(0, e0);
        @(negedge clk);
        start_i = 1'b0;
        wait_until(e0 + 44);
        set_mat('{-128,0,0, 0,-128,0, 0,0,-128});
        kick(-2097152, e0);
        @(negedge clk);
        start_i = 1'b0;
        wait_until(e0 + 44);

        // Held start with a second edge while busy: one computation only.
        set_mat('{2,-1,0, 1,3,2, 0,1,4});
        done_cnt = 0;
        kick(24, e0);
        while (cyc < e0 + 100) begin
            @(negedge clk);
            if (cyc == e0 + 8) start_i = 1'b0;
            if (cyc == e0 + 9) start_i = 1'b1;
            if (cyc == e0) check("busy_first", int'(busy_o), 1);
            if (cyc == e0 + 42) check("busy_done", int'(busy_o), 1);
            if (cyc == e0 + 43) check("busy_end", int'(busy_o), 0);
        end
        start_i = 1'b0;
        check("held_done_count", done_cnt, 1);

        // Reset mid-computation, then start held high through reset release.
        set_mat('{1,2,3, 4,5,6, 7,8,10});
        kick(-3, e0);
        @(negedge clk);
        start_i = 1'b0;
        wait_until(e0 + 19);
        #2 rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        rd_cnt = 0;
        done_cnt = 0;
        #1;
        check("abort_busy", int'(busy_o), 0);
        check("abort_result", int'(result_o), 0);
        check("abort_rd", int'(mem_rd_o), 0);
        set_mat('{2,-1,0, 1,3,2, 0,1,4});
        start_i = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        e0 = cyc + 1;
        expect_run(e0, 24);
        @(negedge clk);
        start_i = 1'b0;
        wait_until(e0 + 43);

        // Back-to-back: new edge sampled on the first IDLE edge.
        set_mat('{1,2,3, 4,5,6, 7,8,10});
        kick(-3, e0);
        @(negedge clk);
        start_i = 1'b0;
        wait_until(e0 + 42);
        set_mat('{3,0,0, 0,-2,0, 0,0,5});
        @(negedge clk);
        start_i = 1'b1;
        expect_run(e0 + 44, -30);
        @(negedge clk);
        start_i = 1'b0;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("addr_queue_empty", addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
